// File: rtl/axis_char_buffer_in_pkg.sv
// axis_char_buffer_in_pkg: default sizing and FSM state encoding for the input character buffer.
package axis_char_buffer_in_pkg;

    localparam int DEF_N        = 16;
    localparam int DEF_CHAR_LEN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_e;

endpackage

// File: rtl/axis_char_buffer_in.sv
// axis_char_buffer_in: AXI-Stream slave that collects one message of up to N characters
// and presents it as a flat vector until the core consumes it.
module axis_char_buffer_in
    import axis_char_buffer_in_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CHAR_LEN = DEF_CHAR_LEN,
    parameter int CNT_W    = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHAR_LEN-1:0]   s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  clear,
    input  logic                  consume,
    output logic [N*CHAR_LEN-1:0] data_out,
    output logic                  data_valid,
    output logic [CNT_W-1:0]      char_cnt,
    output logic                  overflow
);

    state_e                           state_q, state_d;
    logic [N-1:0][CHAR_LEN-1:0]       buf_q, buf_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             ovf_q, ovf_d;
    logic                             accept;

    assign s_axis_tready = (state_q != FULL) && !clear && !rst;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear || (state_q == FULL && consume)) begin
            state_d = IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            state_d = s_axis_tlast ? FULL : RECV;
            // Beats past N are still accepted so the DMA can drain up to TLAST.
            if (cnt_q == CNT_W'(N)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int i = 0; i < N; i++)
                    if (cnt_q == CNT_W'(i)) buf_d[i] = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out   = buf_q;
    assign data_valid = (state_q == FULL);
    assign char_cnt   = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_axis_char_buffer_in.sv
// tb_axis_char_buffer_in: randomized and directed bench for axis_char_buffer_in against a queue model.
module tb_axis_char_buffer_in;

    localparam int N  = 16;
    localparam int CL = 8;
    localparam int CW = $clog2(N + 1);
    localparam int W  = N * CL;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CL-1:0] tdata = '0;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          clear = 1'b0;
    logic          consume = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic [CW-1:0] char_cnt;
    logic          overflow;

    int            checks = 0;
    int            errors = 0;
    int            hs = 0;
    int            h0;
    logic [CL-1:0] q[$];
    logic [CL-1:0] sent[$];
    bit            full = 1'b0;
    logic [W-1:0]  exp_v;

    always #5 clk = ~clk;

    axis_char_buffer_in #(.N(N), .CHAR_LEN(CL)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tdata(tdata),
        .s_axis_tlast(tlast),
        .s_axis_tvalid(tvalid),
        .s_axis_tready(tready),
        .clear(clear),
        .consume(consume),
        .data_out(data_out),
        .data_valid(data_valid),
        .char_cnt(char_cnt),
        .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_data();
        logic [W-1:0] r = '0;
        for (int i = 0; i < N && i < q.size(); i++) r[i*CL +: CL] = q[i];
        return r;
    endfunction

    function automatic logic [W-1:0] sent_data();
        logic [W-1:0] r = '0;
        for (int i = 0; i < N && i < sent.size(); i++) r[i*CL +: CL] = sent[i];
        return r;
    endfunction

    // Model: every accepted beat is queued; the first N form the buffer, extras mean overflow.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            full = 1'b0;
        end else if (clear || (full && consume)) begin
            q.delete();
            full = 1'b0;
        end else if (tvalid && !full) begin
            hs++;
            q.push_back(tdata);
            if (tlast) full = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("tready", W'(tready), W'(!full && !clear && !rst));
        chk("data_valid", W'(data_valid), W'(full));
        chk("char_cnt", W'(char_cnt), W'(q.size() > N ? N : q.size()));
        chk("overflow", W'(overflow), W'(q.size() > N));
        chk("data_out", data_out, model_data());
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [CL-1:0] d, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        sent.push_back(d);
        cyc();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send(input int len, input bit rnd);
        sent.delete();
        for (int i = 0; i < len; i++) begin
            if (rnd)
                while ($urandom % 3 == 0) begin
                    consume = ($urandom % 6 == 0);
                    clear   = ($urandom % 30 == 0);
                    cyc();
                    consume = 1'b0;
                    clear   = 1'b0;
                end
            beat(CL'($urandom), i == len - 1);
        end
    endtask

    task automatic release_msg();
        consume = 1'b1;
        cyc();
        consume = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        cyc(2);
        chk("rst_cnt", W'(char_cnt), '0);
        chk("rst_tready", W'(tready), '0);
        chk("rst_data", data_out, '0);
        rst = 1'b0;
        cyc();

        send(N, 1'b0);
        chk("full_valid", W'(data_valid), W'(1));
        chk("full_cnt", W'(char_cnt), W'(N));
        chk("full_tready", W'(tready), '0);
        chk("full_ovf", W'(overflow), '0);
        chk("full_data", data_out, sent_data());

        h0 = hs;
        tvalid = 1'b1;
        tdata  = 8'hff;
        cyc(5);
        tvalid = 1'b0;
        chk("bp_hs", W'(hs - h0), '0);
        chk("bp_cnt", W'(char_cnt), W'(N));
        release_msg();
        chk("rel_valid", W'(data_valid), '0);
        chk("rel_cnt", W'(char_cnt), '0);
        chk("rel_tready", W'(tready), W'(1));

        sent.delete();
        beat(8'h41, 1'b0);
        beat(8'h42, 1'b0);
        beat(8'h43, 1'b1);
        exp_v = '0;
        exp_v[23:0] = 24'h434241;
        chk("short_cnt", W'(char_cnt), W'(3));
        chk("short_data", data_out, exp_v);
        chk("short_valid", W'(data_valid), W'(1));
        release_msg();

        h0 = hs;
        send(N + 2, 1'b0);
        chk("ovf_hs", W'(hs - h0), W'(N + 2));
        chk("ovf_flag", W'(overflow), W'(1));
        chk("ovf_cnt", W'(char_cnt), W'(N));
        chk("ovf_data", data_out, sent_data());
        release_msg();
        chk("ovf_rel", W'(overflow), '0);

        sent.delete();
        beat(8'h11, 1'b0);
        cyc(2);
        beat(8'h22, 1'b0);
        cyc();
        beat(8'h33, 1'b1);
        exp_v = '0;
        exp_v[23:0] = 24'h332211;
        chk("bub_cnt", W'(char_cnt), W'(3));
        chk("bub_data", data_out, exp_v);
        release_msg();

        for (int it = 0; it < 30; it++) begin
            send($urandom_range(1, N + 3), 1'b1);
            tvalid = $urandom_range(0, 1);
            tdata  = CL'($urandom);
            cyc($urandom_range(0, 3));
            tvalid = 1'b0;
            consume = $urandom_range(0, 1);
            clear   = !consume || ($urandom % 4 == 0);
            cyc();
            consume = 1'b0;
            clear   = 1'b0;
        end

        for (int i = 0; i < 4; i++) beat(CL'(i + 1), 1'b0);
        chk("abort_pre", W'(char_cnt), W'(4));
        #1 rst = 1'b1;
        #1;
        chk("abort_cnt", W'(char_cnt), '0);
        chk("abort_data", data_out, '0);
        chk("abort_tready", W'(tready), '0);
        cyc();
        rst = 1'b0;
        cyc();

        beat(8'h5a, 1'b0);
        beat(8'ha5, 1'b0);
        h0 = hs;
        clear  = 1'b1;
        tvalid = 1'b1;
        tdata  = 8'h77;
        #1;
        chk("clr_tready", W'(tready), '0);
        cyc();
        clear  = 1'b0;
        tvalid = 1'b0;
        chk("clr_hs", W'(hs - h0), '0);
        chk("clr_cnt", W'(char_cnt), '0);
        chk("clr_data", data_out, '0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
